// File: rtl/traffic_pkg.sv
// Shared state encodings and helpers for the N-phase traffic controller.
package traffic_pkg;

   localparam logic [1:0] ST_ALLRED = 2'd0;
   localparam logic [1:0] ST_GREEN  = 2'd1;
   localparam logic [1:0] ST_YELLOW = 2'd2;
   localparam logic [1:0] ST_FLASH  = 2'd3;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/tl_state_timer.sv
// State dwell timer: synchronous clear, free count, done when count hits load-1.
module tl_state_timer
   import traffic_pkg::*;
#(
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic [TW-1:0] i_load,
   output logic          o_done
);

   logic [TW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else            r_cnt <= r_cnt + 1'b1;
   end

   assign o_done = (r_cnt == i_load - 1'b1);

endmodule

// File: rtl/traffic_light_nphase.sv
// N-phase intersection controller with pedestrian service and night flash.
module traffic_light_nphase
   import traffic_pkg::*;
#(
   parameter int NUM_PHASES  = 2,
   parameter int TW          = 8,
   parameter int GREEN_TIME  = 10,
   parameter int EXT_TIME    = 5,
   parameter int YELLOW_TIME = 3,
   parameter int ALLRED_TIME = 2,
   parameter int FLASH_HALF  = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PHASES-1:0]            ped_req,
   input  logic                             flash_en,
   output logic [NUM_PHASES-1:0]            red,
   output logic [NUM_PHASES-1:0]            yellow,
   output logic [NUM_PHASES-1:0]            green,
   output logic [NUM_PHASES-1:0]            walk,
   output logic [clog2(NUM_PHASES)-1:0]     phase,
   output logic                             in_flash
);

   localparam int PW = clog2(NUM_PHASES);
   // One extra bit so GREEN_TIME+EXT_TIME cannot overflow the compare
   localparam int LW = TW + 1;

   logic [1:0]            r_state;
   logic [PW-1:0]         r_phase;
   logic [NUM_PHASES-1:0] r_ped_pend;
   logic                  r_flash;
   logic                  r_first;
   logic                  r_ext;

   logic                  w_done;
   logic                  w_exit;
   logic                  w_clr;
   logic                  w_enter_green;
   logic [LW-1:0]         w_load;
   logic [PW-1:0]         w_nxt_phase;
   logic [NUM_PHASES-1:0] w_clr_mask;

   tl_state_timer #(.TW(LW)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_load (w_load),
      .o_done (w_done)
   );

   always_comb begin
      w_nxt_phase = r_phase + 1'b1;
      if (r_first || r_phase == PW'(NUM_PHASES - 1)) w_nxt_phase = '0;

      w_load = LW'(ALLRED_TIME);
      w_exit = 1'b0;
      unique case (r_state)
         ST_ALLRED: begin
            w_load = LW'(ALLRED_TIME);
            w_exit = w_done;
         end
         ST_GREEN: begin
            w_load = LW'(GREEN_TIME) + (r_ext ? LW'(EXT_TIME) : LW'(0));
            w_exit = w_done;
         end
         ST_YELLOW: begin
            w_load = LW'(YELLOW_TIME);
            w_exit = w_done;
         end
         default: begin
            w_load = LW'(FLASH_HALF);
            w_exit = !flash_en && !r_flash;
         end
      endcase

      // Flash half-period rollover reuses the dwell timer
      w_clr = w_exit || (r_state == ST_FLASH && w_done);

      w_enter_green = (r_state == ST_ALLRED) && w_done && !flash_en;
      w_clr_mask    = '0;
      if (w_enter_green) w_clr_mask[w_nxt_phase] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_ALLRED;
         r_phase    <= '0;
         r_ped_pend <= '0;
         r_flash    <= 1'b0;
         r_first    <= 1'b1;
         r_ext      <= 1'b0;
      end else begin
         r_ped_pend <= (r_ped_pend | ped_req) & ~w_clr_mask;
         unique case (r_state)
            ST_ALLRED: begin
               if (w_done) begin
                  if (flash_en) begin
                     r_state <= ST_FLASH;
                     r_flash <= 1'b1;
                  end else begin
                     r_state <= ST_GREEN;
                     r_phase <= w_nxt_phase;
                     r_ext   <= r_ped_pend[w_nxt_phase]
                              | ped_req[w_nxt_phase];
                     r_first <= 1'b0;
                  end
               end
            end
            ST_GREEN: begin
               if (w_done) r_state <= ST_YELLOW;
            end
            ST_YELLOW: begin
               if (w_done) r_state <= ST_ALLRED;
            end
            default: begin
               if (w_exit) begin
                  r_state <= ST_ALLRED;
                  r_first <= 1'b1;
               end else if (w_done) begin
                  r_flash <= ~r_flash;
               end
            end
         endcase
      end
   end

   always_comb begin
      red      = '1;
      yellow   = '0;
      green    = '0;
      walk     = '0;
      in_flash = 1'b0;
      unique case (r_state)
         ST_GREEN: begin
            red[r_phase]   = 1'b0;
            green[r_phase] = 1'b1;
            walk[r_phase]  = r_ext;
         end
         ST_YELLOW: begin
            red[r_phase]    = 1'b0;
            yellow[r_phase] = 1'b1;
         end
         ST_FLASH: begin
            red       = {NUM_PHASES{r_flash}};
            red[0]    = 1'b0;
            yellow[0] = r_flash;
            in_flash  = 1'b1;
         end
         default: ;
      endcase
   end

   assign phase = r_phase;

endmodule

// File: tb/tb_traffic_light_nphase.sv
// Directed bench for traffic_light_nphase: 2-phase scenarios plus a 4-phase rotation.
module tb_traffic_light_nphase;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] ped_req;
   logic       flash_en;
   logic [1:0] red, yellow, green, walk;
   logic [0:0] phase;
   logic       in_flash;

   logic       rst4;
   logic [3:0] ped4;
   logic       flash4;
   logic [3:0] red4, yellow4, green4, walk4;
   logic [1:0] phase4;
   logic       in_flash4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   traffic_light_nphase dut (
      .clk      (clk),
      .rst      (rst),
      .ped_req  (ped_req),
      .flash_en (flash_en),
      .red      (red),
      .yellow   (yellow),
      .green    (green),
      .walk     (walk),
      .phase    (phase),
      .in_flash (in_flash)
   );

   traffic_light_nphase #(.NUM_PHASES(4)) dut4 (
      .clk      (clk),
      .rst      (rst4),
      .ped_req  (ped4),
      .flash_en (flash4),
      .red      (red4),
      .yellow   (yellow4),
      .green    (green4),
      .walk     (walk4),
      .phase    (phase4),
      .in_flash (in_flash4)
   );

   // Compare {in_flash,phase,red,yellow,green,walk} for len consecutive cycles
   task automatic seg(input string tag, input logic [1:0] r, input logic [1:0] y,
                      input logic [1:0] g, input logic [1:0] w, input logic ph,
                      input logic fl, input int len);
      logic [9:0] exp;
      logic [9:0] obs;
      exp = {fl, ph, r, y, g, w};
      for (int i = 0; i < len; i++) begin
         obs = {in_flash, phase, red, yellow, green, walk};
         checks++;
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d observed=%b expected=%b", tag, i, obs, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic ar(input logic ph, input int len);
      seg("allred", 2'b11, 2'b00, 2'b00, 2'b00, ph, 1'b0, len);
   endtask

   task automatic gr(input logic ph, input logic wk, input int len);
      logic [1:0] oh;
      oh = ph ? 2'b10 : 2'b01;
      seg("green", ~oh, 2'b00, oh, wk ? oh : 2'b00, ph, 1'b0, len);
   endtask

   task automatic ye(input logic ph, input int len);
      logic [1:0] oh;
      oh = ph ? 2'b10 : 2'b01;
      seg("yellow", ~oh, oh, 2'b00, 2'b00, ph, 1'b0, len);
   endtask

   task automatic fl(input logic b, input int len);
      seg("flash", b ? 2'b10 : 2'b00, b ? 2'b01 : 2'b00, 2'b00, 2'b00,
          1'b0, 1'b1, len);
   endtask

   // st: 0 allred, 1 green, 2 yellow
   task automatic seg4(input int st, input int p, input int len);
      logic [3:0]  oh;
      logic [16:0] exp;
      logic [16:0] obs;
      oh  = 4'b0001 << p;
      exp = {1'b0, 2'(p), (st == 0) ? 4'hF : ~oh, (st == 2) ? oh : 4'h0,
             (st == 1) ? oh : 4'h0, 4'h0};
      for (int i = 0; i < len; i++) begin
         obs = {in_flash4, phase4, red4, yellow4, green4, walk4};
         checks++;
         assert (obs === exp) else begin
            errors++;
            $error("FAIL n4 st%0d p%0d cyc %0d observed=%b expected=%b",
                   st, p, i, obs, exp);
         end
         @(negedge clk);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         assert ($countones(green | yellow) <= 1) else begin
            errors++;
            $error("FAIL excl2 observed=%b expected=at most one", green | yellow);
         end
      end
      if (!rst4) begin
         checks++;
         assert ($countones(green4 | yellow4) <= 1) else begin
            errors++;
            $error("FAIL excl4 observed=%b expected=at most one", green4 | yellow4);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] obs;
      rst      = 1'b1;
      rst4     = 1'b1;
      ped_req  = 2'b00;
      flash_en = 1'b0;
      ped4     = 4'h0;
      flash4   = 1'b0;
      @(negedge clk);
      ar(1'b0, 2);
      rst = 1'b0;

      ar(1'b0, 2); gr(1'b0, 1'b0, 10); ye(1'b0, 3); ar(1'b0, 2);
      gr(1'b1, 1'b0, 10); ye(1'b1, 3); ar(1'b1, 2);

      gr(1'b0, 1'b0, 3);
      ped_req = 2'b10;
      gr(1'b0, 1'b0, 1);
      ped_req = 2'b00;
      gr(1'b0, 1'b0, 6); ye(1'b0, 3); ar(1'b0, 2);
      gr(1'b1, 1'b1, 15); ye(1'b1, 3); ar(1'b1, 2);

      gr(1'b0, 1'b0, 4);
      ped_req = 2'b01;
      gr(1'b0, 1'b0, 1);
      ped_req = 2'b00;
      gr(1'b0, 1'b0, 5); ye(1'b0, 3); ar(1'b0, 2);
      gr(1'b1, 1'b0, 10); ye(1'b1, 3); ar(1'b1, 2);
      gr(1'b0, 1'b1, 15); ye(1'b0, 3); ar(1'b0, 2);
      gr(1'b1, 1'b0, 10); ye(1'b1, 3); ar(1'b1, 2);

      gr(1'b0, 1'b0, 3);
      flash_en = 1'b1;
      gr(1'b0, 1'b0, 7); ye(1'b0, 3); ar(1'b0, 2);
      fl(1'b1, 4); fl(1'b0, 4); fl(1'b1, 2);
      flash_en = 1'b0;
      fl(1'b1, 2); fl(1'b0, 1); ar(1'b0, 2);
      gr(1'b0, 1'b0, 10);

      ye(1'b0, 1);
      #2;
      rst = 1'b1;
      #1;
      obs = {in_flash, phase, red, yellow, green, walk};
      checks++;
      assert (obs === 10'b0_0_11_00_00_00) else begin
         errors++;
         $error("FAIL async_rst observed=%b expected=%b", obs, 10'b0_0_11_00_00_00);
      end
      @(negedge clk);
      rst = 1'b0;
      ar(1'b0, 2); gr(1'b0, 1'b0, 10); ye(1'b0, 3); ar(1'b0, 2);
      gr(1'b1, 1'b0, 1);

      rst4 = 1'b0;
      seg4(0, 0, 2);
      for (int p = 0; p < 4; p++) begin
         seg4(1, p, 10);
         seg4(2, p, 3);
         seg4(0, p, 2);
      end
      seg4(1, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
